// File: rtl/gnr_pkg.sv
// Shared constants and reset-divisor helper for the GNR Boolean-network nodes.
package gnr_pkg;

    localparam int DIVW_DEF  = 4;
    localparam int K_MAX     = 6;
    localparam int NCOPY_MAX = 8;

    // Copy 0 comes out of reset at half rate, all others at full rate.
    function automatic int unsigned div_rst(input int unsigned c);
        return (c == 0) ? 1 : 0;
    endfunction

endpackage

// File: rtl/gnr_lut_node_if.sv
// Configuration, run-control and state bus of one gnr_lut_node.
interface gnr_lut_node_if
    import gnr_pkg::*;
#(
    parameter int K     = 4,
    parameter int NCOPY = 2,
    parameter int DIVW  = DIVW_DEF
);
    logic                 lut_we;
    logic [(1<<K)-1:0]    lut_wdata;
    logic                 div_we;
    logic [2:0]           div_sel;
    logic [DIVW-1:0]      div_wdata;
    logic                 reset_nos;
    logic [NCOPY-1:0]     init_state;
    logic [NCOPY-1:0]     start;
    logic [NCOPY*K-1:0]   in_bits;
    logic [NCOPY-1:0]     state;
    logic [NCOPY-1:0]     fire;
    logic [NCOPY-1:0]     changed;
    logic                 agree;

    modport master (
        output lut_we, lut_wdata, div_we, div_sel, div_wdata,
               reset_nos, init_state, start, in_bits,
        input  state, fire, changed, agree
    );

    modport slave (
        input  lut_we, lut_wdata, div_we, div_sel, div_wdata,
               reset_nos, init_state, start, in_bits,
        output state, fire, changed, agree
    );

endinterface

// File: rtl/gnr_copy_stepper.sv
// One state copy: LUT lookup, divisor-gated stepping and fire/changed pulses.
module gnr_copy_stepper #(
    parameter int              K       = 4,
    parameter int              DIVW    = 4,
    parameter logic [DIVW-1:0] DIV_RST = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [(1<<K)-1:0]   i_lut,
    input  logic [K-1:0]        i_idx,
    input  logic                i_start,
    input  logic                i_reset_nos,
    input  logic                i_init,
    input  logic                i_div_we,
    input  logic [DIVW-1:0]     i_div_wdata,
    output logic                o_state,
    output logic                o_fire,
    output logic                o_changed
);
    logic [DIVW-1:0] r_ph;
    logic [DIVW-1:0] r_div;
    logic            r_state;
    logic            r_fire;
    logic            r_changed;
    logic            w_next;

    assign w_next = i_lut[i_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= 1'b0;
            r_ph      <= '0;
            r_div     <= DIV_RST;
            r_fire    <= 1'b0;
            r_changed <= 1'b0;
        end else begin
            // The reload below samples r_div before this write lands.
            if (i_div_we)
                r_div <= i_div_wdata;
            r_fire    <= 1'b0;
            r_changed <= 1'b0;
            if (i_reset_nos) begin
                r_state <= i_init;
                r_ph    <= '0;
            end else if (i_start) begin
                if (r_ph == '0) begin
                    r_state   <= w_next;
                    r_ph      <= r_div;
                    r_fire    <= 1'b1;
                    r_changed <= w_next ^ r_state;
                end else begin
                    r_ph <= r_ph - 1'b1;
                end
            end
        end
    end

    assign o_state   = r_state;
    assign o_fire    = r_fire;
    assign o_changed = r_changed;

endmodule

// File: rtl/gnr_lut_node.sv
// Runtime-programmable K-input LUT node evaluated independently for NCOPY state copies.
module gnr_lut_node
    import gnr_pkg::*;
#(
    parameter int K     = 4,
    parameter int NCOPY = 2,
    parameter int DIVW  = DIVW_DEF
) (
    input  logic           clk,
    input  logic           rst,
    gnr_lut_node_if.slave  bus
);
    logic [(1<<K)-1:0] r_lut;
    logic [NCOPY-1:0]  w_state;
    logic [NCOPY-1:0]  w_fire;
    logic [NCOPY-1:0]  w_changed;
    logic [NCOPY-1:0]  w_div_we;

    // Evaluations this cycle still see the old table.
    always_ff @(posedge clk) begin
        if (rst)
            r_lut <= '0;
        else if (bus.lut_we)
            r_lut <= bus.lut_wdata;
    end

    for (genvar c = 0; c < NCOPY; c++) begin : g_copy
        assign w_div_we[c] = bus.div_we && (bus.div_sel == 3'(c));

        gnr_copy_stepper #(
            .K       (K),
            .DIVW    (DIVW),
            .DIV_RST (DIVW'(div_rst(c)))
        ) u_step (
            .clk         (clk),
            .rst         (rst),
            .i_lut       (r_lut),
            .i_idx       (bus.in_bits[c*K +: K]),
            .i_start     (bus.start[c]),
            .i_reset_nos (bus.reset_nos),
            .i_init      (bus.init_state[c]),
            .i_div_we    (w_div_we[c]),
            .i_div_wdata (bus.div_wdata),
            .o_state     (w_state[c]),
            .o_fire      (w_fire[c]),
            .o_changed   (w_changed[c])
        );
    end

    assign bus.state   = w_state;
    assign bus.fire    = w_fire;
    assign bus.changed = w_changed;
    assign bus.agree   = (&w_state) | ~(|w_state);

endmodule

// File: tb/tb_gnr_lut_node.sv
// Self-checking bench for gnr_lut_node (K=2, NCOPY=3): directed scenarios plus random traffic vs a model.
module tb_gnr_lut_node;
    localparam int K  = 2;
    localparam int NC = 3;
    localparam int DW = 4;
    localparam int LW = 1 << K;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gnr_lut_node_if #(.K(K), .NCOPY(NC), .DIVW(DW)) bus();

    gnr_lut_node #(.K(K), .NCOPY(NC), .DIVW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: per copy, how many starts remain to be skipped before the next evaluation.
    bit          m_valid = 1'b0;
    bit [NC-1:0] m_state, m_fire, m_chg;
    int          m_skip [NC];
    int          m_div  [NC];
    int          m_lut;

    always @(posedge clk) begin : model
        int nd [NC];
        int idx, nv;
        if (rst) begin
            m_valid = 1'b1;
            m_state = '0;
            m_fire  = '0;
            m_chg   = '0;
            m_lut   = 0;
            for (int c = 0; c < NC; c++) begin
                m_skip[c] = 0;
                m_div[c]  = (c == 0) ? 1 : 0;
            end
        end else begin
            for (int c = 0; c < NC; c++) nd[c] = m_div[c];
            if (bus.div_we && bus.div_sel < NC) nd[bus.div_sel] = int'(bus.div_wdata);
            for (int c = 0; c < NC; c++) begin
                m_fire[c] = 1'b0;
                m_chg[c]  = 1'b0;
                if (bus.reset_nos) begin
                    m_state[c] = bus.init_state[c];
                    m_skip[c]  = 0;
                end else if (bus.start[c]) begin
                    if (m_skip[c] == 0) begin
                        idx = int'((bus.in_bits >> (c * K)) % LW);
                        nv  = (m_lut >> idx) & 1;
                        m_chg[c]   = (nv != int'(m_state[c]));
                        m_state[c] = nv[0];
                        m_fire[c]  = 1'b1;
                        m_skip[c]  = m_div[c];
                    end else begin
                        m_skip[c] = m_skip[c] - 1;
                    end
                end
            end
            for (int c = 0; c < NC; c++) m_div[c] = nd[c];
            if (bus.lut_we) m_lut = int'(bus.lut_wdata);
        end
    end

    always @(negedge clk) begin : compare
        if (m_valid) begin
            check("state",   32'(bus.state),   32'(m_state));
            check("fire",    32'(bus.fire),    32'(m_fire));
            check("changed", 32'(bus.changed), 32'(m_chg));
            check("agree",   32'(bus.agree),   32'((m_state == '0) || (m_state == '1)));
        end
    end

    task automatic drive(input bit r, input bit rn, input bit [NC-1:0] init,
                         input bit [NC-1:0] st, input bit [NC*K-1:0] inb,
                         input bit lwe = 1'b0, input bit [LW-1:0] lwd = '0,
                         input bit dwe = 1'b0, input bit [2:0] dsel = '0,
                         input bit [DW-1:0] dwd = '0);
        rst            = r;
        bus.reset_nos  = rn;
        bus.init_state = init;
        bus.start      = st;
        bus.in_bits    = inb;
        bus.lut_we     = lwe;
        bus.lut_wdata  = lwd;
        bus.div_we     = dwe;
        bus.div_sel    = dsel;
        bus.div_wdata  = dwd;
        @(posedge clk);
        #2;
    endtask

    initial begin
        int f0, f1;
        bit [7:0] fpat;
        bus.lut_we = 0; bus.lut_wdata = '0; bus.div_we = 0; bus.div_sel = '0;
        bus.div_wdata = '0; bus.reset_nos = 0; bus.init_state = '0;
        bus.start = '0; bus.in_bits = '0;

        // Reset defaults and default divisor pairing
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        check("rst_state", 32'(bus.state), 0);
        check("rst_fire",  32'(bus.fire),  0);
        check("rst_agree", 32'(bus.agree), 1);
        drive(0, 1, 3'b000, 0, 0);
        f0 = 0; f1 = 0;
        repeat (4) begin
            drive(0, 0, 0, 3'b111, 0);
            f0 += int'(bus.fire[0]);
            f1 += int'(bus.fire[1]);
        end
        check("fires_copy0", 32'(f0), 2);
        check("fires_copy1", 32'(f1), 4);

        // Truth table in0 & ~in1
        drive(0, 1, 3'b000, 0, 0, 1, 4'b0010);
        drive(0, 0, 0, 3'b111, 6'b010101);
        check("tt_set_state",   32'(bus.state),   32'b111);
        check("tt_set_changed", 32'(bus.changed), 32'b111);
        drive(0, 0, 0, 3'b111, 6'b111111);
        check("tt_clr_state",   32'(bus.state),   32'b001);
        check("tt_clr_changed", 32'(bus.changed), 32'b110);
        drive(0, 0, 0, 3'b111, 6'b111111);
        check("tt_half_state",   32'(bus.state),   32'b000);
        check("tt_half_changed", 32'(bus.changed), 32'b001);

        // Divisor reprogram concurrent with a copy-1 evaluation
        drive(0, 1, 3'b000, 0, 0);
        drive(0, 0, 0, 3'b010, 0, 0, '0, 1, 3'd1, 4'd3);
        check("div_same_cycle_fire", 32'(bus.fire), 32'b010);
        fpat = '0;
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 3'b010, 0);
            fpat[i] = bus.fire[1];
        end
        check("div_fire_pattern", 32'(fpat), 32'b0001_0001);

        // Priority
        drive(0, 1, 3'b101, 3'b111, 6'b010101);
        check("prio_nos_state", 32'(bus.state), 32'b101);
        check("prio_nos_fire",  32'(bus.fire),  0);
        drive(1, 1, 3'b111, 3'b111, 0);
        check("prio_rst_state", 32'(bus.state), 0);

        // LUT load concurrent with evaluation
        drive(0, 1, 3'b000, 0, 0);
        drive(0, 0, 0, 3'b010, 0, 1, 4'b1111);
        check("lut_old_state", 32'(bus.state), 0);
        check("lut_old_fire",  32'(bus.fire),  32'b010);
        drive(0, 0, 0, 3'b010, 0);
        check("lut_new_state", 32'(bus.state), 32'b010);

        // Agree tracking with constant-one table
        drive(0, 1, 3'b101, 0, 0);
        check("agree_init", 32'(bus.agree), 0);
        drive(0, 0, 0, 3'b111, 6'b100100);
        check("agree_state",   32'(bus.state),   32'b111);
        check("agree_after",   32'(bus.agree),   1);
        check("agree_changed", 32'(bus.changed), 32'b010);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(63) == 0, $urandom_range(15) == 0,
                  NC'($urandom), NC'($urandom), (NC*K)'($urandom),
                  $urandom_range(7) == 0, LW'($urandom),
                  $urandom_range(5) == 0, 3'($urandom),
                  ($urandom_range(3) == 0) ? DW'($urandom) : DW'($urandom_range(3)));
        end
        drive(0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
